z80_bus_tracer: RTL and testbench

Passive Z80 bus observer that classifies each completed bus cycle (fetch, memory/IO read/write, interrupt acknowledge), queues a compact trace record, and streams it out as 8N1 UART bytes on `TXD`. It sits downstream of the T80 core in the pin-compatible top. It taps the same strobes, address and data pins the core drives. It runs on the internal oscillator clock, asynchronous to `CLK_n`.

---
 rtl/z80_bus_tracer_pkg.sv | 57 +++++
 rtl/z80_bus_tracer_uart_tx_8n1.sv | 89 ++++++++
 rtl/z80_bus_tracer.sv | 194 +++++++++++++++++++
 tb/tb_z80_bus_tracer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_bus_tracer_pkg.sv
// z80_bus_tracer_pkg: shared types, header constants and record byte mux.
// Define Z80_BUS_TRACER_TIMESTAMP_EN to append a 16-bit timestamp to every record.
package z80_bus_tracer_pkg;

    typedef enum logic [2:0] {
        CYC_MEM_RD = 3'd0,
        CYC_MEM_WR = 3'd1,
        CYC_IO_RD  = 3'd2,
        CYC_IO_WR  = 3'd3,
        CYC_FETCH  = 3'd4,
        CYC_INTA   = 3'd5
    } cycle_type_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    localparam logic [3:0] HDR_MAGIC    = 4'hA;
    localparam logic [3:0] HDR_MAGIC_TS = 4'hB;

`ifdef Z80_BUS_TRACER_TIMESTAMP_EN
    localparam int         REC_BYTES = 6;
    localparam logic [3:0] HDR_CUR   = HDR_MAGIC_TS;
`else
    localparam int         REC_BYTES = 4;
    localparam logic [3:0] HDR_CUR   = HDR_MAGIC;
`endif

    typedef struct packed {
        cycle_type_e typ;
        logic        ovf;
        logic [15:0] addr;
        logic [7:0]  data;
`ifdef Z80_BUS_TRACER_TIMESTAMP_EN
        logic [15:0] ts;
`endif
    } trace_rec_t;

    // Byte idx of a record in transmit order; header first.
    function automatic logic [7:0] rec_byte(input trace_rec_t rec, input logic [2:0] idx);
        case (idx)
            3'd0:    rec_byte = {HDR_CUR, rec.ovf, rec.typ};
            3'd1:    rec_byte = rec.addr[15:8];
            3'd2:    rec_byte = rec.addr[7:0];
            3'd3:    rec_byte = rec.data;
`ifdef Z80_BUS_TRACER_TIMESTAMP_EN
            3'd4:    rec_byte = rec.ts[15:8];
            3'd5:    rec_byte = rec.ts[7:0];
`endif
            default: rec_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/z80_bus_tracer_uart_tx_8n1.sv
// uart_tx_8n1: byte transmitter, 8 data bits LSB first, one stop bit.
// ready is also high in the last clk of STOP so consecutive bytes run without a gap.
//
// state    | meaning
// TX_IDLE  | line high, waiting for a byte
// TX_START | start bit (0)
// TX_DATA  | shifting 8 data bits, LSB first
// TX_STOP  | stop bit (1)
module uart_tx_8n1
    import z80_bus_tracer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 108
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    output logic       ready,
    input  logic [7:0] data,
    output logic       txd,
    output logic       idle
);

    localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);

    tx_state_e   state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    assign ready = (state == TX_IDLE) || ((state == TX_STOP) && (cnt == 16'd0));
    assign idle  = (state == TX_IDLE);

    // Bit-timing FSM; cnt is a down-counter reloaded at every bit boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TX_IDLE;
            txd     <= 1'b1;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else if (valid && ready) begin
            state   <= TX_START;
            txd     <= 1'b0;
            shreg   <= data;
            cnt     <= BIT_RELOAD;
            bit_idx <= 3'd0;
        end else begin
            case (state)
                TX_IDLE: txd <= 1'b1;
                TX_START: begin
                    if (cnt == 16'd0) begin
                        state <= TX_DATA;
                        txd   <= shreg[0];
                        cnt   <= BIT_RELOAD;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (cnt == 16'd0) begin
                        cnt <= BIT_RELOAD;
                        if (bit_idx == 3'd7) begin
                            state <= TX_STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shreg[1];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (cnt == 16'd0) begin
                        state <= TX_IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    state <= TX_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/z80_bus_tracer.sv
// z80_bus_tracer: passive Z80 bus observer streaming trace records over UART.
// Z80_BUS_TRACER_TIMESTAMP_EN: latch a clk/16 timestamp at commit, 6-byte records.
module z80_bus_tracer
    import z80_bus_tracer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 108,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic [15:0] a,
    input  logic [7:0]  d,
    output logic        txd,
    output logic        busy,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [4:0]  strb_s1, strb_s2;
    logic [15:0] a_s1, a_s2;
    logic [7:0]  d_s1, d_s2;
    logic        m1, iorq, mreq, rd, wr;
    logic        cur_active;
    cycle_type_e cur_type;
    logic        hold_valid;
    cycle_type_e hold_type;
    logic [15:0] hold_addr;
    logic [7:0]  hold_data;
    logic        commit, push_req, push_ok, pop, pend_ovf;
    trace_rec_t  rec_in, cur_rec;
    trace_rec_t  mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        empty, full;
    logic        seq_active;
    logic [2:0]  byte_idx;
    logic        tx_valid, tx_ready, tx_idle;
    logic [7:0]  tx_data;

    // Two-flop synchronizers; address and data share the strobe delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            strb_s1 <= 5'b0;
            strb_s2 <= 5'b0;
            a_s1    <= 16'h0;
            a_s2    <= 16'h0;
            d_s1    <= 8'h0;
            d_s2    <= 8'h0;
        end else begin
            strb_s1 <= {~m1_n, ~iorq_n, ~mreq_n, ~rd_n, ~wr_n};
            strb_s2 <= strb_s1;
            a_s1    <= a;
            a_s2    <= a_s1;
            d_s1    <= d;
            d_s2    <= d_s1;
        end
    end

    assign {m1, iorq, mreq, rd, wr} = strb_s2;

    // Classify the synchronized strobes; refresh and idle leave cur_active low.
    always_comb begin
        cur_active = 1'b1;
        cur_type   = CYC_MEM_RD;
        if (m1 && iorq)             cur_type = CYC_INTA;
        else if (m1 && mreq && rd)  cur_type = CYC_FETCH;
        else if (mreq && rd)        cur_type = CYC_MEM_RD;
        else if (mreq && wr)        cur_type = CYC_MEM_WR;
        else if (iorq && rd)        cur_type = CYC_IO_RD;
        else if (iorq && wr)        cur_type = CYC_IO_WR;
        else                        cur_active = 1'b0;
    end

    // A cycle ends when its term drops or turns into a different term.
    assign commit   = hold_valid && (!cur_active || (cur_type != hold_type));
    assign push_req = commit && enable;
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop      = !seq_active && !empty && tx_ready;
    assign push_ok  = push_req && (!full || pop);

    // Holding register tracks the last sample of the active cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_type  <= CYC_MEM_RD;
            hold_addr  <= 16'h0;
            hold_data  <= 8'h0;
        end else begin
            hold_valid <= cur_active;
            if (cur_active) begin
                hold_type <= cur_type;
                hold_addr <= a_s2;
                hold_data <= d_s2;
            end
        end
    end

`ifdef Z80_BUS_TRACER_TIMESTAMP_EN
    logic [3:0]  ts_div;
    logic [15:0] ts_cnt;

    // Free-running clk/16 timestamp.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_div <= 4'h0;
            ts_cnt <= 16'h0;
        end else begin
            ts_div <= ts_div + 4'h1;
            if (ts_div == 4'hF) ts_cnt <= ts_cnt + 16'h1;
        end
    end
`endif

    // Record as pushed at commit; ovf reports drops since the last accepted push.
    always_comb begin
        rec_in      = '0;
        rec_in.typ  = hold_type;
        rec_in.ovf  = pend_ovf;
        rec_in.addr = hold_addr;
        rec_in.data = hold_data;
`ifdef Z80_BUS_TRACER_TIMESTAMP_EN
        rec_in.ts   = ts_cnt;
`endif
    end

    // FIFO storage, no reset needed on the data array.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= rec_in;
    end

    // FIFO pointers and drop bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            pend_ovf <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            if (push_req && !push_ok) begin
                pend_ovf <= 1'b1;
                overflow <= 1'b1;
            end else if (push_ok) begin
                pend_ovf <= 1'b0;
            end
        end
    end

    // Byte 0 comes straight from the FIFO head so txd falls on the next clk.
    always_comb begin
        tx_valid = seq_active || !empty;
        tx_data  = seq_active ? rec_byte(cur_rec, byte_idx) : rec_byte(mem[rptr[AW-1:0]], 3'd0);
    end

    // Byte sequencer: pops a whole record, then feeds its remaining bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_active <= 1'b0;
            byte_idx   <= 3'd0;
            cur_rec    <= '0;
        end else if (tx_valid && tx_ready) begin
            if (!seq_active) begin
                cur_rec    <= mem[rptr[AW-1:0]];
                seq_active <= 1'b1;
                byte_idx   <= 3'd1;
            end else if (byte_idx == 3'(REC_BYTES - 1)) begin
                seq_active <= 1'b0;
            end else begin
                byte_idx <= byte_idx + 3'd1;
            end
        end
    end

    assign busy = !empty || seq_active || !tx_idle;

    uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .valid (tx_valid),
        .ready (tx_ready),
        .data  (tx_data),
        .txd   (txd),
        .idle  (tx_idle)
    );

endmodule

// File: tb/tb_z80_bus_tracer.sv
// tb_z80_bus_tracer: scoreboard bench; a UART monitor decodes txd and pops expected bytes.
`timescale 1ns/1ps
module tb_z80_bus_tracer;

    localparam int CPB = 16;
`ifdef Z80_BUS_TRACER_TIMESTAMP_EN
    localparam int         NREC = 6;
    localparam logic [3:0] HDR  = 4'hB;
`else
    localparam int         NREC = 4;
    localparam logic [3:0] HDR  = 4'hA;
`endif

    logic        clk = 1'b0;
    logic        rst, enable;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n;
    logic [15:0] a;
    logic [7:0]  d;
    logic        txd, busy, overflow;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int exp_q[$];
    logic [7:0] ts_q[$];

    z80_bus_tracer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
        .a(a), .d(d), .txd(txd), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_rec(input logic [2:0] typ, input logic [15:0] addr,
                            input logic [7:0] data, input logic ovf);
        exp_q.push_back(int'({HDR, ovf, typ}));
        exp_q.push_back(int'(addr[15:8]));
        exp_q.push_back(int'(addr[7:0]));
        exp_q.push_back(int'(data));
`ifdef Z80_BUS_TRACER_TIMESTAMP_EN
        exp_q.push_back(-1);
        exp_q.push_back(-1);
`endif
    endtask

    // kind: 0 mem rd, 1 mem wr, 2 io rd, 3 io wr, 4 fetch, 5 inta
    task automatic bus_cycle(input int kind, input logic [15:0] addr,
                             input logic [7:0] data, input int hold);
        @(negedge clk);
        a = addr;
        d = data;
        case (kind)
            0: begin mreq_n = 1'b0; rd_n = 1'b0; end
            1: begin mreq_n = 1'b0; wr_n = 1'b0; end
            2: begin iorq_n = 1'b0; rd_n = 1'b0; end
            3: begin iorq_n = 1'b0; wr_n = 1'b0; end
            4: begin m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; end
            default: begin m1_n = 1'b0; iorq_n = 1'b0; end
        endcase
        repeat (hold) @(negedge clk);
        {mreq_n, iorq_n, rd_n, wr_n, m1_n} = 5'b11111;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_pending_bytes"}, exp_q.size(), 0);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic mon_wait(input int n, inout bit ab);
        repeat (n) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
        end
    endtask

    // UART receiver: samples mid-bit, checks framing and gapless spacing inside a record.
    initial begin : monitor
        int s, prev_start, in_rec, e;
        bit ab;
        logic [7:0] b;
        in_rec = 0;
        prev_start = 0;
        b = 8'h00;
        forever begin
            @(negedge clk);
            if (rst || txd !== 1'b0) continue;
            s = cyc;
            if (in_rec != 0) chk("byte_spacing", s - prev_start, 10 * CPB);
            prev_start = s;
            ab = 1'b0;
            mon_wait(CPB / 2, ab);
            if (!ab) chk("start_bit", txd, 0);
            for (int k = 0; k < 8; k++) begin
                if (!ab) begin
                    mon_wait(CPB, ab);
                    b[k] = txd;
                end
            end
            if (!ab) mon_wait(CPB, ab);
            if (ab) begin
                in_rec = 0;
                continue;
            end
            chk("stop_bit", txd, 1);
            in_rec = (in_rec + 1) % NREC;
            if (exp_q.size() == 0) begin
                chk("extra_byte", b, 32'h100);
            end else begin
                e = exp_q.pop_front();
                if (e < 0) ts_q.push_back(b);
                else chk("rx_byte", b, e);
            end
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        logic [15:0] ts0, ts1;
        rst = 1'b1;
        enable = 1'b1;
        {mreq_n, iorq_n, rd_n, wr_n, m1_n} = 5'b11111;
        a = 16'h0;
        d = 8'h0;
        repeat (4) @(negedge clk);
        chk("reset_txd", txd, 1);
        chk("reset_busy", busy, 0);
        chk("reset_overflow", overflow, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single memory write
        push_rec(3'd1, 16'h1234, 8'h5A, 1'b0);
        bus_cycle(1, 16'h1234, 8'h5A, 10);
        wait_drain("single_write", 3000);

        // fetch followed directly by refresh: one record only
        push_rec(3'd4, 16'h0000, 8'hF3, 1'b0);
        @(negedge clk);
        a = 16'h0000; d = 8'hF3;
        m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
        repeat (6) @(negedge clk);
        m1_n = 1'b1; rd_n = 1'b1; a = 16'h0042; d = 8'h00;
        repeat (6) @(negedge clk);
        mreq_n = 1'b1;
        repeat (4) @(negedge clk);
        wait_drain("fetch_refresh", 3000);
        chk("overflow_before_burst", overflow, 0);

        // burst of 20 IO writes: one goes straight to the UART, 16 queue, 3 drop
        for (int i = 0; i < 20; i++) begin
            if (i < 17) push_rec(3'd3, 16'h3000 + 16'(i), 8'(i), 1'b0);
            bus_cycle(3, 16'h3000 + 16'(i), 8'(i), 3);
        end
        chk("overflow_set", overflow, 1);
        chk("busy_burst", busy, 1);
        n = 0;
        while (exp_q.size() > 15 * NREC && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("space_freed", exp_q.size() <= 15 * NREC, 1);
        push_rec(3'd3, 16'h3100, 8'hE1, 1'b1);
        bus_cycle(3, 16'h3100, 8'hE1, 3);
        push_rec(3'd3, 16'h3101, 8'hE2, 1'b0);
        bus_cycle(3, 16'h3101, 8'hE2, 3);
        wait_drain("overflow_drain", 20000);
        chk("overflow_sticky", overflow, 1);

        // interrupt acknowledge
        push_rec(3'd5, 16'h0038, 8'hFF, 1'b0);
        bus_cycle(5, 16'h0038, 8'hFF, 5);
        wait_drain("inta", 3000);

        // capture disabled: nothing queued or sent
        enable = 1'b0;
        bus_cycle(1, 16'h2000, 8'h11, 5);
        chk("disabled_busy_0", busy, 0);
        bus_cycle(2, 16'h0010, 8'h22, 5);
        chk("disabled_busy_1", busy, 0);
        bus_cycle(4, 16'h0100, 8'h33, 5);
        chk("disabled_busy_2", busy, 0);
        repeat (20 * CPB) @(negedge clk);
        chk("disabled_busy_end", busy, 0);
        enable = 1'b1;
        push_rec(3'd2, 16'h00FE, 8'h7E, 1'b0);
        bus_cycle(2, 16'h00FE, 8'h7E, 5);
        wait_drain("reenable", 3000);

        // reset in the middle of the first byte
        bus_cycle(1, 16'hBEEF, 8'h11, 5);
        n = 0;
        while (txd !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("frame_started", txd, 0);
        repeat (5 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_txd", txd, 1);
        chk("midreset_busy", busy, 0);
        chk("midreset_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push_rec(3'd1, 16'h4321, 8'hC3, 1'b0);
        bus_cycle(1, 16'h4321, 8'hC3, 6);
        wait_drain("after_reset", 3000);

`ifdef Z80_BUS_TRACER_TIMESTAMP_EN
        // two commits 1600 clks apart: timestamps differ by 100
        ts_q.delete();
        @(negedge clk);
        n = cyc;
        push_rec(3'd1, 16'h5555, 8'h01, 1'b0);
        bus_cycle(1, 16'h5555, 8'h01, 4);
        while (cyc < n + 1600) @(negedge clk);
        push_rec(3'd1, 16'h6666, 8'h02, 1'b0);
        bus_cycle(1, 16'h6666, 8'h02, 4);
        wait_drain("timestamp", 5000);
        chk("ts_byte_count", ts_q.size(), 4);
        if (ts_q.size() == 4) begin
            ts0 = {ts_q[0], ts_q[1]};
            ts1 = {ts_q[2], ts_q[3]};
            chk("ts_delta", 16'(ts1 - ts0), 100);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
